data_mem_arbiter: RTL and testbench
===================================

DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 7, SHALL set the word-address width (128-word variable data memory).
REQ-002 Parameter DATA_W, default 32, SHALL set the data width.
REQ-003 Parameter STARVE_LIMIT, default 4, legal range 1..15, SHALL set the number of lost cycles after which port B wins.
REQ-004 CLK  in  1  SHALL be the single clock; every register updates on its rising edge.
REQ-005 RESET  in  1  SHALL be a synchronous, active-high reset.
REQ-006 a_req / a_we  in  1 / 1  SHALL carry the CPU-port request and write-enable.
REQ-007 a_addr / a_wdata  in  ADDR_W / DATA_W  SHALL carry the CPU-port word address and write data.
REQ-008 a_gnt / a_rvalid  out  1 / 1  SHALL carry the CPU-port grant (combinational) and the read-data valid (registered).
REQ-009 a_rdata  out  DATA_W  SHALL carry the CPU-port read data.
REQ-010 The b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid and b_rdata ports SHALL be identical to the a_* ports and serve the debug/IO port (DIP readout).
REQ-011 mem_en / mem_we  out  1 / 1  SHALL drive the single-port RAM enable and write strobe (combinational).
REQ-012 mem_addr / mem_wdata  out  ADDR_W / DATA_W  SHALL drive the RAM address and write data.
REQ-013 mem_rdata  in  DATA_W  SHALL carry RAM read data, valid one cycle after an enabled read.

Function
REQ-014 At most one of a_gnt and b_gnt SHALL be high in any cycle; a_gnt SHALL be high only while a_req is high, and b_gnt only while b_req is high.
REQ-015 Default priority: port A SHALL win when both ports request; port B SHALL be granted when it is the only requester.
REQ-016 Starvation counter: the counter SHALL increment (saturating at STARVE_LIMIT) every cycle in which b_req=1 and b_gnt=0, and SHALL clear when b_gnt=1 or b_req=0.
REQ-017 When the counter equals STARVE_LIMIT and b_req=1, port B SHALL win even if a_req=1.
REQ-018 Grant cycle: mem_en=1, and mem_we, mem_addr and mem_wdata SHALL equal the winner's we, addr and wdata.
REQ-019 No-grant cycle: mem_en=0 and mem_we=0.
REQ-020 A granted read (we=0) SHALL be latched as a pending read with the winner as owner.
REQ-021 In the next cycle, that owner's rvalid SHALL be 1 for exactly one cycle, and its rdata SHALL equal mem_rdata.
REQ-022 A granted write SHALL produce no rvalid.
REQ-023 a_rdata and b_rdata SHALL be 0 when their own rvalid is 0.
REQ-024 Back-to-back grants SHALL be allowed every cycle (throughput 1 access/cycle); a read return and a new grant in the same cycle SHALL both proceed.
REQ-025 Requesters SHALL hold req and payload stable until gnt; a req dropped before gnt SHALL be treated as withdrawn, with no side effects.
REQ-026 Addresses SHALL be word addresses; no range check is performed (decode is done upstream).

Reset
REQ-027 While RESET=1: starvation counter=0, pending read cleared, a_rvalid=b_rvalid=0, a_rdata=b_rdata=0, a_gnt=b_gnt=0, mem_en=mem_we=0.
REQ-028 A read granted in the cycle before RESET asserts SHALL NOT produce rvalid.
REQ-029 The first grant SHALL be possible in the first cycle after RESET deasserts.

Configuration
REQ-030 With macro DATA_MEM_ARB_STARVE_GUARD_EN defined, REQ-016 and REQ-017 SHALL apply.
REQ-031 Without DATA_MEM_ARB_STARVE_GUARD_EN, the counter SHALL be absent and port A SHALL always have strict priority; all other requirements are unchanged.

Verification
REQ-032 Only B reads addr 0x05 while RAM[5]=0x0000ABCD -> b_gnt same cycle; next cycle b_rvalid=1 and b_rdata=0x0000ABCD; a_rvalid=0.
REQ-033 A writes 0x12345678 to 0x01 and B reads 0x02 in the same cycle -> a_gnt=1, b_gnt=0, mem_we=1, mem_addr=0x01; B granted next cycle if A has idled.
REQ-034 A requests every cycle and B holds a read with guard enabled -> B loses 4 cycles, b_gnt=1 in the 5th cycle, then A resumes; with the macro undefined, b_gnt never asserts.
REQ-035 Alternating reads A@0x10 and B@0x11 on consecutive cycles -> rvalid alternates A, B with matching data and no cycle gap.
REQ-036 A read is granted, then RESET=1 on the next edge -> a_rvalid stays 0, all outputs are 0, and the counter is 0.
REQ-037 b_req is pulsed for 2 cycles while A holds priority and then dropped -> the counter clears to 0, no B grant, and no memory access for B.

Source files
------------

// File: rtl/data_mem_arbiter.sv
// rtl/data_mem_arbiter.sv - two-port arbiter in front of a single-port data RAM
//
// Purpose
//   Shares one single-port RAM between port A (CPU) and port B (debug/IO,
//   DIP readout). Grants are combinational, so the RAM sees the winner's
//   access in the same cycle. Read data returns to the owning port one cycle
//   later. Throughput is one access per cycle.
//
// Configuration
//   DATA_MEM_ARB_STARVE_GUARD_EN : when defined, port B wins after losing
//   STARVE_LIMIT consecutive cycles. When undefined, port A always has strict
//   priority and the starvation counter is not built.
//
// Ports
//   CLK, RESET          : clock, synchronous active-high reset
//   a_req/a_we          : port A request / write enable
//   a_addr/a_wdata      : port A word address / write data
//   a_gnt               : port A grant (combinational)
//   a_rvalid/a_rdata    : port A read return (rdata is 0 unless rvalid)
//   b_*                 : same set for port B
//   mem_en/mem_we       : RAM enable / write strobe (combinational)
//   mem_addr/mem_wdata  : RAM address / write data
//   mem_rdata           : RAM read data, valid one cycle after an enabled read

module data_mem_arbiter #(
  parameter int ADDR_W       = 7,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              CLK,
  input  logic              RESET,

  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,

  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,

  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  // High when port B must win regardless of port A.
  logic starve_hit;

`ifdef DATA_MEM_ARB_STARVE_GUARD_EN
  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_cnt_q;
  logic [CNT_W-1:0] starve_cnt_d;

  assign starve_hit = b_req && (starve_cnt_q == LIMIT);

  // Counts consecutive cycles in which B asks and loses; any B grant or
  // B withdrawal starts the count over.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!b_req || b_gnt) begin
      starve_cnt_d = '0;
    end else if (starve_cnt_q != LIMIT) begin
      starve_cnt_d = starve_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end
`else
  // STARVE_LIMIT is at least 1, so this is constant low: A keeps strict
  // priority.
  assign starve_hit = b_req && (STARVE_LIMIT == 0);
`endif

  // Grant decision. Nothing is granted while RESET is high.
  logic a_win;
  logic b_win;

  always_comb begin
    b_win = b_req && (!a_req || starve_hit);
    a_win = a_req && !b_win;
    a_gnt = a_win && !RESET;
    b_gnt = b_win && !RESET;
  end

  // RAM drive: winner's payload, everything low when idle.
  always_comb begin
    mem_en    = a_gnt || b_gnt;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (b_gnt) begin
      mem_we    = b_we;
      mem_addr  = b_addr;
      mem_wdata = b_wdata;
    end else if (a_gnt) begin
      mem_we    = a_we;
      mem_addr  = a_addr;
      mem_wdata = a_wdata;
    end
  end

  // Pending read: one outstanding read, tagged with the port that owns it.
  logic pend_vld_q;
  logic pend_vld_d;
  logic pend_own_b_q;
  logic pend_own_b_d;

  always_comb begin
    pend_vld_d   = mem_en && !mem_we;
    pend_own_b_d = b_gnt;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      pend_vld_q   <= 1'b0;
      pend_own_b_q <= 1'b0;
    end else begin
      pend_vld_q   <= pend_vld_d;
      pend_own_b_q <= pend_own_b_d;
    end
  end

  // The return is masked by RESET so that a read granted just before reset
  // asserts never shows up on rvalid.
  always_comb begin
    a_rvalid = pend_vld_q && !pend_own_b_q && !RESET;
    b_rvalid = pend_vld_q &&  pend_own_b_q && !RESET;
    a_rdata  = a_rvalid ? mem_rdata : '0;
    b_rdata  = b_rvalid ? mem_rdata : '0;
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb/tb_data_mem_arbiter.sv - directed scoreboard bench for data_mem_arbiter

module tb_data_mem_arbiter;

  logic        CLK;
  logic        RESET;
  logic        a_req, a_we, a_gnt, a_rvalid;
  logic [6:0]  a_addr;
  logic [31:0] a_wdata, a_rdata;
  logic        b_req, b_we, b_gnt, b_rvalid;
  logic [6:0]  b_addr;
  logic [31:0] b_wdata, b_rdata;
  logic        mem_en, mem_we;
  logic [6:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;

  data_mem_arbiter #(.ADDR_W(7), .DATA_W(32), .STARVE_LIMIT(4)) dut (
    .CLK(CLK), .RESET(RESET),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [31:0] init_val(input logic [6:0] addr);
    if (addr == 7'h05) return 32'h0000ABCD;
    return 32'hC0DE0000 | {25'd0, addr};
  endfunction

  // RAM environment: one-cycle read latency, preloaded while RESET is high.
  logic [31:0] ram [128];
  always @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < 128; i++) ram[i] <= init_val(7'(i));
      mem_rdata <= 32'd0;
    end else if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr];
    end
  end

  typedef struct packed {
    logic        port_b;
    logic [31:0] data;
  } ret_t;

  ret_t        exp_q[$];
  logic [31:0] shadow [128];
  int          n_pass;
  int          n_total;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic reset_shadow();
    for (int i = 0; i < 128; i++) shadow[i] = init_val(7'(i));
  endtask

  task automatic check_ret(input string tag);
    ret_t        e;
    logic        ea, eb;
    logic [31:0] ed;
    ea = 1'b0; eb = 1'b0; ed = 32'd0;
    if (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      ea = !e.port_b;
      eb = e.port_b;
      ed = e.data;
    end
    chk({tag, ".a_rvalid"}, 32'(a_rvalid), 32'(ea));
    chk({tag, ".b_rvalid"}, 32'(b_rvalid), 32'(eb));
    chk({tag, ".a_rdata"},  a_rdata, ea ? ed : 32'd0);
    chk({tag, ".b_rdata"},  b_rdata, eb ? ed : 32'd0);
  endtask

  // One bus cycle: drive, check grant/RAM side, record expectations, clock,
  // then check the read return against the scoreboard.
  task automatic cyc(input string tag,
                     input logic ar, input logic aw, input logic [6:0] aa, input logic [31:0] ad,
                     input logic br, input logic bw, input logic [6:0] ba, input logic [31:0] bd,
                     input logic eag, input logic ebg);
    a_req = ar; a_we = aw; a_addr = aa; a_wdata = ad;
    b_req = br; b_we = bw; b_addr = ba; b_wdata = bd;
    #2;
    chk({tag, ".a_gnt"},  32'(a_gnt),  32'(eag));
    chk({tag, ".b_gnt"},  32'(b_gnt),  32'(ebg));
    chk({tag, ".mem_en"}, 32'(mem_en), 32'(eag | ebg));
    chk({tag, ".mem_we"}, 32'(mem_we), ebg ? 32'(bw) : (eag ? 32'(aw) : 32'd0));
    if (ebg) begin
      chk({tag, ".mem_addr"}, 32'(mem_addr), 32'(ba));
      if (bw) begin
        chk({tag, ".mem_wdata"}, mem_wdata, bd);
        shadow[ba] = bd;
      end else begin
        exp_q.push_back('{port_b: 1'b1, data: shadow[ba]});
      end
    end else if (eag) begin
      chk({tag, ".mem_addr"}, 32'(mem_addr), 32'(aa));
      if (aw) begin
        chk({tag, ".mem_wdata"}, mem_wdata, ad);
        shadow[aa] = ad;
      end else begin
        exp_q.push_back('{port_b: 1'b0, data: shadow[aa]});
      end
    end
    @(posedge CLK);
    #1;
    check_ret(tag);
  endtask

  task automatic idle(input string tag);
    cyc(tag, 1'b0, 1'b0, 7'h0, 32'h0, 1'b0, 1'b0, 7'h0, 32'h0, 1'b0, 1'b0);
  endtask

  // A reads every cycle while B holds a read of 0x20.
  task automatic starve_run(input string tag);
    for (int i = 0; i < 4; i++)
      cyc({tag, ".lose"}, 1'b1, 1'b0, 7'(8'h40 + i), 32'h0, 1'b1, 1'b0, 7'h20, 32'h0, 1'b1, 1'b0);
`ifdef DATA_MEM_ARB_STARVE_GUARD_EN
    cyc({tag, ".win"},    1'b1, 1'b0, 7'h44, 32'h0, 1'b1, 1'b0, 7'h20, 32'h0, 1'b0, 1'b1);
    cyc({tag, ".resume"}, 1'b1, 1'b0, 7'h44, 32'h0, 1'b0, 1'b0, 7'h20, 32'h0, 1'b1, 1'b0);
`else
    for (int i = 0; i < 4; i++)
      cyc({tag, ".strict"}, 1'b1, 1'b0, 7'(8'h44 + i), 32'h0, 1'b1, 1'b0, 7'h20, 32'h0, 1'b1, 1'b0);
    cyc({tag, ".a_idle"}, 1'b0, 1'b0, 7'h00, 32'h0, 1'b1, 1'b0, 7'h20, 32'h0, 1'b0, 1'b1);
`endif
    idle({tag, ".flush"});
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    reset_shadow();
    RESET = 1'b1;
    a_req = 1'b1; a_we = 1'b0; a_addr = 7'h05; a_wdata = 32'h0;
    b_req = 1'b1; b_we = 1'b0; b_addr = 7'h06; b_wdata = 32'h0;

    // Reset state, with both ports requesting.
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    chk("rst.a_gnt",    32'(a_gnt),    32'd0);
    chk("rst.b_gnt",    32'(b_gnt),    32'd0);
    chk("rst.mem_en",   32'(mem_en),   32'd0);
    chk("rst.mem_we",   32'(mem_we),   32'd0);
    chk("rst.a_rvalid", 32'(a_rvalid), 32'd0);
    chk("rst.b_rvalid", 32'(b_rvalid), 32'd0);
    chk("rst.a_rdata",  a_rdata,       32'd0);
    chk("rst.b_rdata",  b_rdata,       32'd0);
    RESET = 1'b0;

    // First cycle after reset: grant possible immediately.
    cyc("first", 1'b1, 1'b0, 7'h05, 32'h0, 1'b0, 1'b0, 7'h00, 32'h0, 1'b1, 1'b0);

    // B alone reads 0x05.
    cyc("b_only", 1'b0, 1'b0, 7'h00, 32'h0, 1'b1, 1'b0, 7'h05, 32'h0, 1'b0, 1'b1);
    idle("b_only.ret");

    // A write vs B read in the same cycle; B served once A idles.
    cyc("a_wr_b_rd", 1'b1, 1'b1, 7'h01, 32'h12345678, 1'b1, 1'b0, 7'h02, 32'h0, 1'b1, 1'b0);
    cyc("b_after",   1'b0, 1'b0, 7'h00, 32'h0,        1'b1, 1'b0, 7'h02, 32'h0, 1'b0, 1'b1);
    cyc("a_readbk",  1'b1, 1'b0, 7'h01, 32'h0,        1'b0, 1'b0, 7'h00, 32'h0, 1'b1, 1'b0);
    idle("a_readbk.ret");

    // B write produces no return; read it back.
    cyc("b_wr", 1'b0, 1'b0, 7'h00, 32'h0, 1'b1, 1'b1, 7'h30, 32'hDEADBEEF, 1'b0, 1'b1);
    cyc("b_rd", 1'b0, 1'b0, 7'h00, 32'h0, 1'b1, 1'b0, 7'h30, 32'h0,        1'b0, 1'b1);
    idle("b_rd.ret");

    // Alternating reads, returns back to back.
    for (int i = 0; i < 2; i++) begin
      cyc("alt.a", 1'b1, 1'b0, 7'h10, 32'h0, 1'b0, 1'b0, 7'h00, 32'h0, 1'b1, 1'b0);
      cyc("alt.b", 1'b0, 1'b0, 7'h00, 32'h0, 1'b1, 1'b0, 7'h11, 32'h0, 1'b0, 1'b1);
    end
    idle("alt.ret");

    starve_run("starve");

    // B pulses twice and withdraws; its count must restart from zero.
    cyc("pulse", 1'b1, 1'b0, 7'h50, 32'h0, 1'b1, 1'b0, 7'h21, 32'h0, 1'b1, 1'b0);
    cyc("pulse", 1'b1, 1'b0, 7'h51, 32'h0, 1'b1, 1'b0, 7'h21, 32'h0, 1'b1, 1'b0);
    cyc("drop",  1'b1, 1'b0, 7'h52, 32'h0, 1'b0, 1'b0, 7'h21, 32'h0, 1'b1, 1'b0);
    starve_run("after_drop");

    // Build up B's lost count, then reset right after an A read grant.
    cyc("pre_rst", 1'b1, 1'b0, 7'h07, 32'h0, 1'b1, 1'b0, 7'h08, 32'h0, 1'b1, 1'b0);
    a_req = 1'b1; a_we = 1'b0; a_addr = 7'h05;
    b_req = 1'b1; b_we = 1'b0; b_addr = 7'h08;
    #2;
    chk("rd_rst.a_gnt", 32'(a_gnt), 32'd1);
    @(posedge CLK); #1;
    RESET = 1'b1;
    #1;
    chk("rd_rst.a_rvalid", 32'(a_rvalid), 32'd0);
    chk("rd_rst.b_rvalid", 32'(b_rvalid), 32'd0);
    chk("rd_rst.a_rdata",  a_rdata,       32'd0);
    chk("rd_rst.a_gnt2",   32'(a_gnt),    32'd0);
    chk("rd_rst.b_gnt2",   32'(b_gnt),    32'd0);
    chk("rd_rst.mem_en",   32'(mem_en),   32'd0);
    @(posedge CLK); #1;
    chk("rd_rst.hold_rvalid", 32'(a_rvalid), 32'd0);
    RESET = 1'b0;
    reset_shadow();
    exp_q.delete();
    starve_run("after_rst");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
